// File: rtl/imul_var_lat_ctrl.sv
// Iterative 32x32 -> low-32 multiplier with variable latency.
// Runs of up to 8 zero multiplier bits are skipped in a single cycle.
module imul_var_lat_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [31:0] req_msg_a,
  input  logic [31:0] req_msg_b,
  input  logic        req_sd,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_msg,
  output logic        resp_sd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_reg, b_reg, result;
  logic [31:0] a_nxt, b_nxt, result_nxt;
  logic        sd_reg, sd_nxt;
  logic [3:0]  skip_n;

  // Trailing-zero count of the low byte; 8 when the whole byte is zero.
  always_comb begin
    skip_n = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (b_reg[i]) skip_n = 4'(i);
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a_reg;
    b_nxt      = b_reg;
    result_nxt = result;
    sd_nxt     = sd_reg;
    req_rdy    = 1'b0;
    resp_val   = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          a_nxt      = req_msg_a;
          b_nxt      = req_msg_b;
          result_nxt = '0;
          sd_nxt     = req_sd;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        if (b_reg == '0) begin
          state_nxt = DONE;
        end else if (b_reg[0]) begin
          result_nxt = result + a_reg;
          a_nxt      = a_reg << 1;
          b_nxt      = b_reg >> 1;
        end else begin
          a_nxt = a_reg << skip_n;
          b_nxt = b_reg >> skip_n;
        end
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      sd_reg <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_reg  <= a_nxt;
      b_reg  <= b_nxt;
      result <= result_nxt;
      sd_reg <= sd_nxt;
    end
  end

  // Response fields mirror the registers so they hold in IDLE until the next accept.
  assign resp_msg = result;
  assign resp_sd  = sd_reg;
  assign busy     = (state == CALC) || (state == DONE);

endmodule

// File: tb/tb_imul_var_lat_ctrl.sv
// Directed bench for imul_var_lat_ctrl: products, latencies, backpressure, reset.
module tb_imul_var_lat_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_msg_a;
  logic [31:0] req_msg_b;
  logic        req_sd;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;
  logic        resp_sd;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  imul_var_lat_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_msg_a (req_msg_a),
    .req_msg_b (req_msg_b),
    .req_sd    (req_sd),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_msg  (resp_msg),
    .resp_sd   (resp_sd),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
  // lat counts the cycle after the accept edge as 1; 999 means no response arrived.
  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic sd,
                        output int lat, output logic [31:0] msg, output logic sd_o);
    req_val   = 1'b1;
    req_msg_a = a;
    req_msg_b = b;
    req_sd    = sd;
    resp_rdy  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val   = 1'b0;
    req_msg_a = 32'hA5A5_A5A5;
    req_msg_b = 32'h5A5A_5A5A;
    lat = 1;
    while (!resp_val && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    msg  = resp_msg;
    sd_o = resp_sd;
    if (!resp_val) lat = 999;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_val   = 1'b0;
    req_msg_a = '0;
    req_msg_b = '0;
    req_sd    = 1'b0;
    resp_rdy  = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_rdy, resp_val, resp_msg, resp_sd, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b val=%b msg=%h sd=%b busy=%b, want 1 0 0 0 0",
               req_rdy, resp_val, resp_msg, resp_sd, busy);
    end
    reset_n = 1'b1;
  endtask

  // Runs immediately after reset release, so it also checks the first-edge accept.
  task automatic test_basic();
    int lat; logic [31:0] msg; logic sd;
    do_txn(32'd3, 32'd5, 1'b1, lat, msg, sd);
    n_checks++;
    if (lat !== 5 || msg !== 32'd15 || sd !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_3x5: got lat=%0d msg=%0d sd=%b, want lat=5 msg=15 sd=1", lat, msg, sd);
    end
    n_checks++;
    if (req_rdy !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_resp: got rdy=%b busy=%b, want 1 0", req_rdy, busy);
    end
  endtask

  task automatic test_zero();
    int lat; logic [31:0] msg; logic sd;
    do_txn(32'd7, 32'd0, 1'b0, lat, msg, sd);
    n_checks++;
    if (lat !== 2 || msg !== 32'd0 || sd !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_b: got lat=%0d msg=%h sd=%b, want lat=2 msg=0 sd=0", lat, msg, sd);
    end
  endtask

  task automatic test_skip();
    int lat; logic [31:0] msg; logic sd;
    do_txn(32'd1, 32'h8000_0000, 1'b1, lat, msg, sd);
    n_checks++;
    if (lat !== 7 || msg !== 32'h8000_0000 || sd !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_msb: got lat=%0d msg=%h sd=%b, want lat=7 msg=80000000 sd=1", lat, msg, sd);
    end
    // full-byte skip then add: 0x10 * 0x300
    do_txn(32'h10, 32'h300, 1'b0, lat, msg, sd);
    n_checks++;
    if (lat !== 5 || msg !== 32'h3000 || sd !== 1'b0) begin
      n_fail++;
      $display("FAIL skip_byte: got lat=%0d msg=%h sd=%b, want lat=5 msg=3000 sd=0", lat, msg, sd);
    end
    do_txn(32'd5, 32'h100, 1'b1, lat, msg, sd);
    n_checks++;
    if (lat !== 4 || msg !== 32'h500) begin
      n_fail++;
      $display("FAIL skip_8: got lat=%0d msg=%h, want lat=4 msg=500", lat, msg);
    end
    do_txn(32'hDEAD_BEEF, 32'd1, 1'b0, lat, msg, sd);
    n_checks++;
    if (lat !== 3 || msg !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL b_one: got lat=%0d msg=%h, want lat=3 msg=deadbeef", lat, msg);
    end
  endtask

  task automatic test_max();
    int lat; logic [31:0] msg; logic sd;
    do_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, msg, sd);
    n_checks++;
    if (lat !== 34 || msg !== 32'h1) begin
      n_fail++;
      $display("FAIL max_lat: got lat=%0d msg=%h, want lat=34 msg=00000001", lat, msg);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic stable;
    req_val   = 1'b1;
    req_msg_a = 32'd3;
    req_msg_b = 32'd5;
    req_sd    = 1'b1;
    resp_rdy  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // request stays asserted with junk operands; they must be ignored
    req_msg_a = 32'd100;
    req_msg_b = 32'd100;
    req_sd    = 1'b0;
    lat = 1;
    while (!resp_val && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 5 || resp_msg !== 32'd15 || resp_sd !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_first: got lat=%0d msg=%0d sd=%b, want lat=5 msg=15 sd=1", lat, resp_msg, resp_sd);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_val !== 1'b1 || resp_msg !== 32'd15 || resp_sd !== 1'b1 || req_rdy !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
    end
    n_checks++;
    if (stable !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got val=%b msg=%0d sd=%b rdy=%b, want stable 1 15 1 0",
               resp_val, resp_msg, resp_sd, req_rdy);
    end
    req_msg_a = 32'd4;
    req_msg_b = 32'd6;
    req_sd    = 1'b0;
    resp_rdy  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_rdy !== 1'b1 || resp_val !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b val=%b busy=%b, want 1 0 0", req_rdy, resp_val, busy);
    end
    @(negedge clk);
    req_val = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || req_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_accept: got busy=%b rdy=%b, want 1 0", busy, req_rdy);
    end
    lat = 1;
    while (!resp_val && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 5 || resp_msg !== 32'd24 || resp_sd !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_second: got lat=%0d msg=%0d sd=%b, want lat=5 msg=24 sd=0", lat, resp_msg, resp_sd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midcalc();
    int lat; logic [31:0] msg; logic sd; logic seen;
    req_val   = 1'b1;
    req_msg_a = 32'd3;
    req_msg_b = 32'd5;
    req_sd    = 1'b1;
    resp_rdy  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({req_rdy, resp_val, resp_msg, resp_sd, busy} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midcalc_reset: got rdy=%b val=%b msg=%h sd=%b busy=%b, want 1 0 0 0 0",
               req_rdy, resp_val, resp_msg, resp_sd, busy);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_val !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL dropped_txn: got resp_val seen=%b, want 0", seen);
    end
    do_txn(32'd2, 32'd3, 1'b0, lat, msg, sd);
    n_checks++;
    if (lat !== 4 || msg !== 32'd6 || sd !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_2x3: got lat=%0d msg=%0d sd=%b, want lat=4 msg=6 sd=0", lat, msg, sd);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_skip();
    test_max();
    test_back_to_back();
    test_reset_midcalc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
